alu_bist_ctrl: RTL and testbench

//   On-chip stimulus generator and checker for the 4-bit alu (AND/OR/XOR/ADD).
//   On start, it drives all 1024 {sel,a,b} combinations into the alu.

---
 rtl/alu_bist_if.sv | 25 ++
 rtl/alu_bist_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_bist_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_bist_if.sv
// Bus between the BIST controller and the 4-bit alu under test.
// master = controller (drives operands, reads result); slave = alu.
interface alu_bist_if;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_out;
  logic       alu_carry;

  modport master (
    output alu_a,
    output alu_b,
    output alu_sel,
    input  alu_out,
    input  alu_carry
  );

  modport slave (
    input  alu_a,
    input  alu_b,
    input  alu_sel,
    output alu_out,
    output alu_carry
  );
endinterface

// File: rtl/alu_bist_ctrl.sv
// Exhaustive BIST for the 4-bit alu: walks all 1024 {sel,a,b} vectors,
// compares {carry,out} with a golden model and reports count, first failure and pass.
module alu_bist_ctrl #(
  parameter int SETTLE       = 1,
  parameter int ERR_W        = 8,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  // start is a single-cycle request honoured only in IDLE or DONE; there is no
  // ready signal, busy=1 tells the requester that a pulse would be dropped.
  input  logic              start,
  alu_bist_if.master        alu,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [9:0]        first_fail_vec,
  output logic              first_fail_vld,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int              CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam bit              STOP        = (STOP_ON_FAIL != 0);

  logic [1:0]       state;
  logic [9:0]       vec;
  logic [CNT_W-1:0] settle_cnt;
  logic [ERR_W-1:0] err_q;
  logic             pass_q;
  logic [9:0]       ff_vec_q;
  logic             ff_vld_q;

  logic [4:0]       golden;
  logic [4:0]       observed;
  logic             mismatch;
  logic             last_vec;
  logic             err_sat;
  logic             start_ok;

  // Golden alu: logic ops never carry, ADD yields a 5-bit sum.
  always_comb begin
    golden = 5'd0;
    case (vec[9:8])
      2'b00:   golden = {1'b0, vec[7:4] & vec[3:0]};
      2'b01:   golden = {1'b0, vec[7:4] | vec[3:0]};
      2'b10:   golden = {1'b0, vec[7:4] ^ vec[3:0]};
      default: golden = {1'b0, vec[7:4]} + {1'b0, vec[3:0]};
    endcase
  end

  assign observed = {alu.alu_carry, alu.alu_out};
  assign mismatch = (observed != golden);
  assign last_vec = (vec == 10'd1023);
  assign err_sat  = (err_q == {ERR_W{1'b1}});
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      vec        <= 10'd0;
      settle_cnt <= '0;
      err_q      <= '0;
      pass_q     <= 1'b0;
      ff_vec_q   <= 10'd0;
      ff_vld_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state      <= S_DRIVE;
            vec        <= 10'd0;
            settle_cnt <= '0;
            err_q      <= '0;
            pass_q     <= 1'b0;
            ff_vec_q   <= 10'd0;
            ff_vld_q   <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            if (!err_sat) err_q <= err_q + ERR_W'(1);
            if (!ff_vld_q) begin
              ff_vec_q <= vec;
              ff_vld_q <= 1'b1;
            end
          end
          // vec is left on the last vector driven so DONE shows where the run ended.
          if (last_vec || (STOP && mismatch)) begin
            state  <= S_DONE;
            pass_q <= !mismatch && (err_q == '0);
          end else begin
            vec   <= vec + 10'd1;
            state <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign alu.alu_sel     = vec[9:8];
  assign alu.alu_a       = vec[7:4];
  assign alu.alu_b       = vec[3:0];

  assign busy            = (state == S_DRIVE) || (state == S_CHECK);
  assign done            = (state == S_DONE);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_fail_vec  = ff_vec_q;
  assign first_fail_vld  = ff_vld_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: a fault-injectable alu model drives two controllers
// (run-all, SETTLE=1 and stop-on-fail, SETTLE=2); results are set against an enumerating reference.
module tb_alu_bist_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic start_m = 1'b0;
  logic start_s = 1'b0;

  alu_bist_if bif_m ();
  alu_bist_if bif_s ();

  logic       busy_m, done_m, pass_m, ffl_m;
  logic [7:0] err_m;
  logic [9:0] ffv_m;
  logic [1:0] st_m;
  logic       busy_s, done_s, pass_s, ffl_s;
  logic [7:0] err_s;
  logic [9:0] ffv_s;
  logic [1:0] st_s;

  alu_bist_ctrl #(.SETTLE(1), .ERR_W(8), .STOP_ON_FAIL(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .start(start_m), .alu(bif_m.master),
    .busy(busy_m), .done(done_m), .pass(pass_m), .err_count(err_m),
    .first_fail_vec(ffv_m), .first_fail_vld(ffl_m), .state_dbg(st_m)
  );

  alu_bist_ctrl #(.SETTLE(2), .ERR_W(8), .STOP_ON_FAIL(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .alu(bif_s.master),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
    .first_fail_vec(ffv_s), .first_fail_vld(ffl_s), .state_dbg(st_s)
  );

  // ---------------- alu model with stuck-at fault ----------------
  bit fm_en = 0; int fm_bit = 0; bit fm_val = 0;
  bit fs_en = 0; int fs_bit = 0; bit fs_val = 0;

  function automatic logic [4:0] alu_ref(input logic [1:0] sel, input logic [3:0] a, input logic [3:0] b);
    int r;
    case (sel)
      2'd0:    r = int'(a & b);
      2'd1:    r = int'(a | b);
      2'd2:    r = int'(a ^ b);
      default: r = int'(a) + int'(b);
    endcase
    return r[4:0];
  endfunction

  function automatic logic [4:0] apply_fault(input logic [4:0] v, input bit en, input int fb, input bit fv);
    logic [4:0] r;
    r = v;
    if (en) r[fb] = fv;
    return r;
  endfunction

  assign {bif_m.alu_carry, bif_m.alu_out} =
    apply_fault(alu_ref(bif_m.alu_sel, bif_m.alu_a, bif_m.alu_b), fm_en, fm_bit, fm_val);
  assign {bif_s.alu_carry, bif_s.alu_out} =
    apply_fault(alu_ref(bif_s.alu_sel, bif_s.alu_a, bif_s.alu_b), fs_en, fs_bit, fs_val);

  // ---------------- reference model ----------------
  // Enumerates every vector the controller would visit and reports what it should end with.
  function automatic void model_run(input bit en, input int fb, input bit fv, input bit stop,
                                    output int errs, output int ff, output bit fvld, output int last);
    logic [4:0] good;
    errs = 0; ff = 0; fvld = 0; last = 1023;
    for (int v = 0; v < 1024; v++) begin
      good = alu_ref(2'(v / 256), 4'((v / 16) % 16), 4'(v % 16));
      if (apply_fault(good, en, fb, fv) != good) begin
        if (!fvld) begin fvld = 1; ff = v; end
        errs++;
        if (stop) begin last = v; break; end
      end
    end
    if (errs > 255) errs = 255;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input bit which, output int c0);
    @(negedge clk);
    if (which) start_s = 1'b1; else start_m = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    start_s = 1'b0;
    start_m = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int c0, output int dt);
    dt = -1;
    for (int i = 0; i < 8000; i++) begin
      @(posedge clk);
      #1;
      if (which ? done_s : done_m) begin
        dt = cyc - c0;
        break;
      end
    end
  endtask

  task automatic wait_vec_m(input int target, input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (int'({bif_m.alu_sel, bif_m.alu_a, bif_m.alu_b}) == target) begin
        found = 1;
        break;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic run_m_check(input string tag);
    int c0, dt, e_err, e_ff, e_last;
    bit e_vld;
    model_run(fm_en, fm_bit, fm_val, 0, e_err, e_ff, e_vld, e_last);
    pulse_start(0, c0);
    wait_done(0, c0, dt);
    chk({tag, "_cycles"}, 32'(dt), 32'd2048);
    chk({tag, "_err"}, 32'(err_m), 32'(e_err));
    chk({tag, "_ffvld"}, 32'(ffl_m), 32'(e_vld));
    chk({tag, "_ffvec"}, 32'(ffv_m), 32'(e_ff));
    chk({tag, "_pass"}, 32'(pass_m), 32'(e_err == 0));
    chk({tag, "_lastvec"}, 32'({bif_m.alu_sel, bif_m.alu_a, bif_m.alu_b}), 32'd1023);
  endtask

  task automatic run_s_check(input string tag);
    int c0, dt, e_err, e_ff, e_last;
    bit e_vld;
    model_run(fs_en, fs_bit, fs_val, 1, e_err, e_ff, e_vld, e_last);
    pulse_start(1, c0);
    wait_done(1, c0, dt);
    chk({tag, "_cycles"}, 32'(dt), 32'((e_last + 1) * 3));
    chk({tag, "_err"}, 32'(err_s), 32'(e_err));
    chk({tag, "_ffvec"}, 32'(ffv_s), 32'(e_ff));
    chk({tag, "_ffvld"}, 32'(ffl_s), 32'(e_vld));
    chk({tag, "_pass"}, 32'(pass_s), 32'(e_err == 0));
    chk({tag, "_lastvec"}, 32'({bif_s.alu_sel, bif_s.alu_a, bif_s.alu_b}), 32'(e_last));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int c0, c1, dt;

    // Reset state
    #12;
    chk("rst_m_outputs", 32'({busy_m, done_m, pass_m, err_m, ffv_m, ffl_m, st_m}), 32'd0);
    chk("rst_m_vec", 32'({bif_m.alu_sel, bif_m.alu_a, bif_m.alu_b}), 32'd0);
    chk("rst_s_outputs", 32'({busy_s, done_s, pass_s, err_s, ffv_s, ffl_s, st_s}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: golden alu
    fm_en = 0;
    pulse_start(0, c0);
    chk("t1_busy_after_start", 32'({busy_m, done_m}), 32'b10);
    wait_done(0, c0, dt);
    chk("t1_cycles", 32'(dt), 32'd2048);
    chk("t1_pass", 32'(pass_m), 32'd1);
    chk("t1_err", 32'(err_m), 32'd0);
    chk("t1_ffvld", 32'(ffl_m), 32'd0);
    chk("t1_lastvec", 32'({bif_m.alu_sel, bif_m.alu_a, bif_m.alu_b}), 32'd1023);

    // T2: alu_out[0] stuck-at-0
    fm_en = 1; fm_bit = 0; fm_val = 0;
    run_m_check("t2");
    chk("t2_err_const", 32'(err_m), 32'd255);
    chk("t2_ff_const", 32'(ffv_m), 32'd17);

    // T3: carry stuck-at-0
    fm_bit = 4;
    run_m_check("t3");
    chk("t3_err_const", 32'(err_m), 32'd120);
    chk("t3_ff_const", 32'(ffv_m), 32'd799);

    // T4: stop on first fail (SETTLE=2 instance)
    fs_en = 1; fs_bit = 0; fs_val = 0;
    run_s_check("t4");
    chk("t4_a", 32'(bif_s.alu_a), 32'd1);
    chk("t4_b", 32'(bif_s.alu_b), 32'd1);
    chk("t4_err_const", 32'(err_s), 32'd1);

    // T5: reset in the middle of a run
    fm_en = 0;
    pulse_start(0, c0);
    wait_vec_m(300, "t5_reach_300");
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_outputs", 32'({busy_m, done_m, pass_m, err_m, ffv_m, ffl_m, st_m}), 32'd0);
    chk("t5_async_vec", 32'({bif_m.alu_sel, bif_m.alu_a, bif_m.alu_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_m_check("t5_rerun");

    // T6: start while busy is ignored; start in DONE clears results
    fm_en = 1; fm_bit = 4; fm_val = 0;
    pulse_start(0, c0);
    wait_vec_m(500, "t6_reach_500");
    pulse_start(0, c1);
    chk("t6_still_busy", 32'({busy_m, done_m}), 32'b10);
    wait_done(0, c0, dt);
    chk("t6_cycles", 32'(dt), 32'd2048);
    chk("t6_err", 32'(err_m), 32'd120);
    chk("t6_ff", 32'(ffv_m), 32'd799);
    fm_en = 0;
    pulse_start(0, c1);
    chk("t6_cleared", 32'({done_m, pass_m, err_m, ffl_m, ffv_m}), 32'd0);
    wait_done(0, c1, dt);
    chk("t6_rerun_cycles", 32'(dt), 32'd2048);
    chk("t6_rerun_pass", 32'(pass_m), 32'd1);

    // Randomized stuck-at faults on both controllers
    for (int k = 0; k < 3; k++) begin
      fm_en = 1;
      fm_bit = int'($urandom_range(0, 4));
      fm_val = 1'($urandom_range(0, 1));
      run_m_check($sformatf("rnd_m%0d_b%0d_v%0d", k, fm_bit, fm_val));
    end
    for (int k = 0; k < 2; k++) begin
      fs_en = 1;
      fs_bit = int'($urandom_range(0, 4));
      fs_val = 1'($urandom_range(0, 1));
      run_s_check($sformatf("rnd_s%0d_b%0d_v%0d", k, fs_bit, fs_val));
    end
    fs_en = 0;
    run_s_check("s_clean");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
